// File: rtl/div16x8_seq.sv
// div16x8_seq: sequential restoring divider, 16-bit dividend / 8-bit divisor.
// Produces one quotient bit per clock (MSB first) behind a start/done handshake.
// Divide-by-zero and quotient-overflow are detected on the accepting edge and
// finish in a single cycle with quotient 8'hFF and remainder 0.
//
// Ports:
//   clk          system clock, rising edge
//   srst         synchronous active-high reset
//   start        request, sampled only in IDLE and DONE
//   dividend     16-bit numerator, captured on the accepting edge
//   divisor      8-bit denominator, captured on the accepting edge
//   quotient     registered 8-bit quotient, held until the next accepted start
//   remainder    registered 8-bit remainder, held like quotient
//   done         high while in DONE
//   busy         high while in CALC
//   div_by_zero  last operation had divisor 0
//   overflow     last operation's quotient did not fit in 8 bits
//   state_out    current state: IDLE=00, CALC=01, DONE=10
module div16x8_seq (
  input  logic        clk,
  input  logic        srst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic [7:0]  quotient,
  output logic [7:0]  remainder,
  output logic        done,
  output logic        busy,
  output logic        div_by_zero,
  output logic        overflow,
  output logic [1:0]  state_out
);

  localparam logic [1:0] StIdle = 2'b00;
  localparam logic [1:0] StCalc = 2'b01;
  localparam logic [1:0] StDone = 2'b10;

  logic [1:0] state_q, state_d;
  logic [3:0] count_q, count_d;
  logic [7:0] rem_q, rem_d;     // partial remainder, always < divisor
  logic [7:0] low_q, low_d;     // remaining dividend bits, MSB consumed first
  logic [7:0] quo_q, quo_d;     // quotient shift register
  logic [7:0] dvs_q, dvs_d;     // captured divisor
  logic [7:0] quotient_q, quotient_d;
  logic [7:0] remainder_q, remainder_d;
  logic       dbz_q, dbz_d;
  logic       ovf_q, ovf_d;

  // One restoring step: shift in next dividend bit, subtract if it fits.
  logic [8:0] trial;
  logic [8:0] diff;
  logic       fits;
  logic [7:0] rem_step;
  logic [7:0] quo_step;

  always_comb begin
    trial    = {rem_q, low_q[7]};
    diff     = trial - {1'b0, dvs_q};
    fits     = (trial >= {1'b0, dvs_q});
    rem_step = fits ? diff[7:0] : trial[7:0];
    quo_step = {quo_q[6:0], fits};
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    low_d       = low_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          dvs_d = divisor;
          dbz_d = 1'b0;
          ovf_d = 1'b0;
          if (divisor == 8'h00) begin
            dbz_d       = 1'b1;
            quotient_d  = 8'hFF;
            remainder_d = 8'h00;
            state_d     = StDone;
          end else if (dividend[15:8] >= divisor) begin
            ovf_d       = 1'b1;
            quotient_d  = 8'hFF;
            remainder_d = 8'h00;
            state_d     = StDone;
          end else begin
            rem_d   = dividend[15:8];
            low_d   = dividend[7:0];
            quo_d   = 8'h00;
            count_d = 4'd0;
            state_d = StCalc;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StCalc: begin
        rem_d   = rem_step;
        low_d   = {low_q[6:0], 1'b0};
        quo_d   = quo_step;
        count_d = count_q + 4'd1;
        if (count_q == 4'd7) begin
          quotient_d  = quo_step;
          remainder_d = rem_step;
          state_d     = StDone;
        end
      end
      default: state_d = StIdle;  // unused encoding recovers, outputs untouched
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= StIdle;
      count_q     <= 4'd0;
      rem_q       <= 8'h00;
      low_q       <= 8'h00;
      quo_q       <= 8'h00;
      dvs_q       <= 8'h00;
      quotient_q  <= 8'h00;
      remainder_q <= 8'h00;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      low_q       <= low_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  // Status outputs decode the state register only; no input reaches an output.
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
  assign done        = (state_q == StDone);
  assign busy        = (state_q == StCalc);
  assign state_out   = state_q;

endmodule
